serial_pattern_tx: RTL and testbench

//  Serial bit-stream transmitter: loads a parallel pattern and shifts it out one bit
//  per clock on x, LSB first, with start/busy/done handshake. Transmit-side counterpart
//  of the fsm sequence detector: x drives the detector's inp so benches and top-levels

---
 rtl/serial_pattern_tx_pkg.sv | 21 ++
 rtl/serial_pattern_tx.sv | 130 +++++++++++++
 tb/tb_serial_pattern_tx.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_tx_pkg.sv
//------------------------------------------------------------------------------
// Module : serial_pattern_tx_pkg
// Brief  : State encodings shared by the serial transmit/receive blocks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_pattern_tx_pkg;

  localparam int c_state_w = 2;

  typedef enum logic [c_state_w-1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/serial_pattern_tx.sv
//------------------------------------------------------------------------------
// Module : serial_pattern_tx
// Brief  : Loads a parallel pattern and shifts it out LSB first on x, with
//          start/busy/done handshake. Define SERIAL_PATTERN_TX_PARITY_EN to
//          append one even-parity bit after the data bits.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [LEN_W-1:0] c_width = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] c_one   = LEN_W'(1);

  tx_state_t        r_state;
  tx_state_t        w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [LEN_W-1:0] r_bitcnt;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_accept;
  logic             w_x;
  logic             w_valid;
  logic             w_busy;
  logic             w_done;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  logic             r_parity;
`endif

  assign w_len_clamped = (len > c_width) ? c_width : len;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and output decode; outputs depend only on registers
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_x          = 1'b0;
    w_valid      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          w_accept     = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_x     = r_shreg[0];
        w_valid = 1'b1;
        w_busy  = 1'b1;
        if (r_bitcnt == c_one) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          w_next_state = ST_PARITY;
`else
          w_next_state = ST_DONE;
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      ST_PARITY: begin
        w_x          = r_parity;
        w_valid      = 1'b1;
        w_busy       = 1'b1;
        w_next_state = ST_DONE;
      end
`endif
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // PISO shift register, bit down-counter and running parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (w_accept) begin
      r_shreg  <= pattern;
      r_bitcnt <= w_len_clamped;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else if (r_state == ST_SHIFT) begin
      r_shreg  <= r_shreg >> 1;
      r_bitcnt <= r_bitcnt - c_one;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      r_parity <= r_parity ^ r_shreg[0];
`endif
    end
  end

  assign x     = w_x;
  assign valid = w_valid;
  assign busy  = w_busy;
  assign done  = w_done;

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
//------------------------------------------------------------------------------
// Module : tb_serial_pattern_tx
// Brief  : Directed self-checking bench for serial_pattern_tx (both builds of
//          SERIAL_PATTERN_TX_PARITY_EN).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       x;
  logic       valid;
  logic       busy;
  logic       done;

  int n_checks;
  int n_pass;

  serial_pattern_tx #(.WIDTH(8), .LEN_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pattern = 8'h00; len = 4'd0;
    step();
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0000)
      $display("FAIL reset_outputs got=%b want=0000", {x, valid, busy, done});
    else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0010;
    pattern = 8'b1011_0010; len = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({x, valid, busy, done} !== {exp_bits[i], 3'b110})
        $display("FAIL basic_bit%0d got=%b want=%b", i, {x, valid, busy, done}, {exp_bits[i], 3'b110});
      else n_pass++;
      step();
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0110)
      $display("FAIL basic_parity got=%b want=0110", {x, valid, busy, done});
    else n_pass++;
    step();
`endif
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL basic_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0000)
      $display("FAIL basic_idle got=%b want=0000", {x, valid, busy, done});
    else n_pass++;
  endtask

  task automatic test_short_and_zero();
    int activity;
    pattern = 8'hFF; len = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({x, valid, busy, done} !== 4'b1110)
        $display("FAIL len3_bit%0d got=%b want=1110", i, {x, valid, busy, done});
      else n_pass++;
      step();
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    n_checks++;
    if ({x, valid, busy, done} !== 4'b1110)
      $display("FAIL len3_parity got=%b want=1110", {x, valid, busy, done});
    else n_pass++;
    step();
`endif
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL len3_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
    // len==0 requests must be ignored entirely
    len = 4'd0; start = 1'b1;
    activity = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (valid || busy || done) activity++;
    end
    start = 1'b0;
    n_checks++;
    if (activity !== 0)
      $display("FAIL len0_ignored active_cycles=%0d want=0", activity);
    else n_pass++;
    step();
  endtask

  task automatic test_clamp();
    logic [7:0] exp_bits;
    exp_bits = 8'h81;
    pattern = 8'h81; len = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({x, valid, busy} !== {exp_bits[i], 2'b11})
        $display("FAIL clamp_bit%0d got=%b want=%b", i, {x, valid, busy}, {exp_bits[i], 2'b11});
      else n_pass++;
      step();
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0110)
      $display("FAIL clamp_parity got=%b want=0110", {x, valid, busy, done});
    else n_pass++;
    step();
`endif
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL clamp_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bits;
    int         dones;
    exp_bits = 8'b0110_1001;
    pattern = 8'b0110_1001; len = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    pattern = 8'h00; len = 4'd1;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        n_checks++;
        if ({x, valid} !== {exp_bits[i], 1'b1})
          $display("FAIL midstart_bit%0d got=%b want=%b", i, {x, valid}, {exp_bits[i], 1'b1});
        else n_pass++;
      end
      if (done) dones++;
      start = (i == 2 || i == 5);
      step();
    end
    start = 1'b0;
    n_checks++;
    if (dones !== 1)
      $display("FAIL midstart_dones got=%0d want=1", dones);
    else n_pass++;

    // start held high: next transfer accepted on the edge ending the IDLE cycle
    pattern = 8'b0000_0010; len = 4'd2; start = 1'b1;
    step();
    n_checks++;
    if ({x, valid, busy} !== 3'b011)
      $display("FAIL held_bit0 got=%b want=011", {x, valid, busy});
    else n_pass++;
    step();
    n_checks++;
    if ({x, valid, busy} !== 3'b111)
      $display("FAIL held_bit1 got=%b want=111", {x, valid, busy});
    else n_pass++;
    step();
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    step();
`endif
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL held_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0000)
      $display("FAIL held_idle got=%b want=0000", {x, valid, busy, done});
    else n_pass++;
    step();
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0110)
      $display("FAIL held_restart got=%b want=0110", {x, valid, busy, done});
    else n_pass++;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) dones++;
    end
    n_checks++;
    if (dones !== 1)
      $display("FAIL held_second_done got=%0d want=1", dones);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    logic [7:0] exp_bits;
    int         dones;
    pattern = 8'hF0; len = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if ({x, valid, busy} !== 3'b111)
      $display("FAIL rst_pre_bit4 got=%b want=111", {x, valid, busy});
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0000)
      $display("FAIL rst_async_drop got=%b want=0000", {x, valid, busy, done});
    else n_pass++;
    step();
    step();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || valid) dones++;
    end
    n_checks++;
    if (dones !== 0)
      $display("FAIL rst_no_done active_cycles=%0d want=0", dones);
    else n_pass++;
    exp_bits = 8'b1100_1010;
    pattern = 8'b1100_1010; len = 4'd8; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({x, valid} !== {exp_bits[i], 1'b1})
        $display("FAIL rst_resend_bit%0d got=%b want=%b", i, {x, valid}, {exp_bits[i], 1'b1});
      else n_pass++;
      step();
    end
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_parity_loopback();
    logic [3:0] exp_bits;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    pattern = 8'b0000_0111; len = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({x, valid, busy} !== 3'b111)
        $display("FAIL par7_cycle%0d got=%b want=111", i, {x, valid, busy});
      else n_pass++;
      step();
    end
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL par7_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
`endif
    // Detector stimulus 1,1,0,1
    exp_bits = 4'b1011;
    pattern = 8'b0000_1011; len = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({x, valid} !== {exp_bits[i], 1'b1})
        $display("FAIL loop_bit%0d got=%b want=%b", i, {x, valid}, {exp_bits[i], 1'b1});
      else n_pass++;
      step();
    end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    n_checks++;
    if ({x, valid} !== 2'b11)
      $display("FAIL loop_parity got=%b want=11", {x, valid});
    else n_pass++;
    step();
`endif
    n_checks++;
    if ({x, valid, busy, done} !== 4'b0001)
      $display("FAIL loop_done got=%b want=0001", {x, valid, busy, done});
    else n_pass++;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    len      = '0;
    test_reset();
    test_basic();
    test_short_and_zero();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    test_parity_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
